// File: rtl/prio_dec_pkg.sv
// Shared constants for the index-to-mask decoder and its bitmap-builder siblings.
package prio_dec_pkg;

    // Index width, shared with the priority encoder's msb output.
    localparam int PRIO_DEC_IDX_W = 8;

    // Frame FSM encodings.
    localparam logic [0:0] PRIO_DEC_ST_ACCUM = 1'b0;
    localparam logic [0:0] PRIO_DEC_ST_HOLD  = 1'b1;

    // Per-beat decode modes.
    localparam logic PRIO_DEC_MODE_ONEHOT = 1'b0;
    localparam logic PRIO_DEC_MODE_THERM  = 1'b1;

    // Mask width as an unsigned (IDX_W+1)-bit value, so that WIDTH_LOG=8 yields
    // 256 and no 8-bit index can ever reach it.
    function automatic logic [PRIO_DEC_IDX_W:0] prio_dec_width_ext(input int width_log);
        return (PRIO_DEC_IDX_W + 1)'(1 << width_log);
    endfunction

endpackage

// File: rtl/prio_dec_bit.sv
// Combinational decode of one bit index into a one-hot or thermometer mask.
// Out-of-range indices decode to an empty mask and raise range_err.
module prio_dec_bit
    import prio_dec_pkg::*;
#(
    parameter int WIDTH_LOG = 4,
    localparam int WIDTH    = 1 << WIDTH_LOG
) (
    input  logic [PRIO_DEC_IDX_W-1:0] idx,
    input  logic                      mode,
    output logic [WIDTH-1:0]          mask,
    output logic                      range_err
);

    localparam logic [PRIO_DEC_IDX_W:0] WIDTH_EXT = prio_dec_width_ext(WIDTH_LOG);

    logic [PRIO_DEC_IDX_W:0] idx_ext_s;

    // Per-bit compare against the zero-extended index; the thermometer form
    // never builds (2 << idx), so idx = WIDTH-1 cleanly gives all ones.
    always_comb begin
        idx_ext_s = {1'b0, idx};
        range_err = (idx_ext_s >= WIDTH_EXT);
        mask      = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (range_err) begin
                mask[i] = 1'b0;
            end else if (mode == PRIO_DEC_MODE_THERM) begin
                mask[i] = ((PRIO_DEC_IDX_W + 1)'(i) <= idx_ext_s);
            end else begin
                mask[i] = ((PRIO_DEC_IDX_W + 1)'(i) == idx_ext_s);
            end
        end
    end

endmodule

// File: rtl/prio_dec_chk.sv
// Protocol checker for prio_dec, observing its ports only.
module prio_dec_chk #(
    parameter int WIDTH = 16
) (
    input logic             clk,
    input logic             rst,
    input logic             in_ready,
    input logic             out_valid,
    input logic             out_ready,
    input logic [WIDTH-1:0] out_mask,
    input logic             out_err
);

    // A held frame always blocks new beats.
    a_valid_blocks_ready: assert property (@(posedge clk) disable iff (rst)
        out_valid |-> !in_ready);

    // A stalled frame keeps its mask and error flag.
    a_stall_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> ($stable(out_mask) && $stable(out_err)));

endmodule

// File: rtl/prio_dec.sv
// Frame-level index decoder: ORs the decoded masks of every beat up to the
// last one, then holds the finished mask until the consumer takes it.
module prio_dec
    import prio_dec_pkg::*;
#(
    parameter int WIDTH_LOG = 4,
    localparam int WIDTH    = 1 << WIDTH_LOG
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [PRIO_DEC_IDX_W-1:0] in_idx,
    input  logic                      in_mode,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [WIDTH-1:0]          out_mask,
    output logic                      out_err
);

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] out_mask_q, out_mask_d;
    logic             out_err_q, out_err_d;

    logic [WIDTH-1:0] dec_mask_s;
    logic             dec_err_s;
    logic             beat_take_s;

    prio_dec_bit #(
        .WIDTH_LOG (WIDTH_LOG)
    ) u_bit (
        .idx       (in_idx),
        .mode      (in_mode),
        .mask      (dec_mask_s),
        .range_err (dec_err_s)
    );

    // Handshake flags come from the state register only; in_ready is also
    // held low while reset is asserted.
    assign in_ready    = (state_q == PRIO_DEC_ST_ACCUM) && !rst;
    assign out_valid   = (state_q == PRIO_DEC_ST_HOLD);
    assign beat_take_s = in_valid && in_ready;
    assign out_mask    = out_mask_q;
    assign out_err     = out_err_q;

    // Next-state logic: accumulate beats in ACCUM, publish on the last beat,
    // wait in HOLD until the output handshake.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        err_d      = err_q;
        out_mask_d = out_mask_q;
        out_err_d  = out_err_q;
        case (state_q)
            PRIO_DEC_ST_ACCUM: begin
                if (beat_take_s && in_last) begin
                    out_mask_d = acc_q | dec_mask_s;
                    out_err_d  = err_q | dec_err_s;
                    acc_d      = '0;
                    err_d      = 1'b0;
                    state_d    = PRIO_DEC_ST_HOLD;
                end else if (beat_take_s) begin
                    acc_d   = acc_q | dec_mask_s;
                    err_d   = err_q | dec_err_s;
                    state_d = PRIO_DEC_ST_ACCUM;
                end else begin
                    state_d = PRIO_DEC_ST_ACCUM;
                end
            end
            PRIO_DEC_ST_HOLD: begin
                if (out_ready) begin
                    state_d = PRIO_DEC_ST_ACCUM;
                end else begin
                    state_d = PRIO_DEC_ST_HOLD;
                end
            end
            default: begin
                state_d    = PRIO_DEC_ST_ACCUM;
                acc_d      = '0;
                err_d      = 1'b0;
                out_mask_d = '0;
                out_err_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers with synchronous reset that discards any
    // partially accumulated frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= PRIO_DEC_ST_ACCUM;
            acc_q      <= '0;
            err_q      <= 1'b0;
            out_mask_q <= '0;
            out_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            err_q      <= err_d;
            out_mask_q <= out_mask_d;
            out_err_q  <= out_err_d;
        end
    end

endmodule

// File: tb/tb_prio_dec.sv
// Randomised and directed bench for prio_dec with a queue-based scoreboard.
module tb_prio_dec;

    localparam int WL = 4;
    localparam int W  = 1 << WL;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_mode, in_last;
    logic [7:0]   in_idx;
    logic         out_valid, out_ready, out_err;
    logic [W-1:0] out_mask;

    typedef struct {
        logic [W-1:0] mask;
        bit           err;
        bit           chk_enc;
        int           max_idx;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    bit   rand_bp = 1'b0;

    // Reference accumulator for the frame in progress.
    logic [W-1:0] m_acc;
    bit           m_err, m_therm;
    int           m_max;

    prio_dec #(.WIDTH_LOG(WL)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_idx(in_idx), .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_mask(out_mask), .out_err(out_err)
    );

    prio_dec_chk #(.WIDTH(W)) u_chk (
        .clk(clk), .rst(rst), .in_ready(in_ready), .out_valid(out_valid),
        .out_ready(out_ready), .out_mask(out_mask), .out_err(out_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference decode straight from the arithmetic definition.
    function automatic logic [W-1:0] ref_dec(input int idx, input bit mode);
        longint one = 1;
        if (idx >= W) return '0;
        if (mode) return W'((one << (idx + 1)) - 1);
        return W'(one << idx);
    endfunction

    // Priority encoder reference: index of the highest set bit, -1 if none.
    function automatic int ref_enc(input logic [W-1:0] m);
        for (int i = W - 1; i >= 0; i--) begin
            if (m[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_clear();
        m_acc = '0; m_err = 1'b0; m_therm = 1'b0; m_max = -1;
    endtask

    // Offer one beat until it is accepted, then update the model.
    task automatic send_beat(input int idx, input bit mode, input bit last);
        int n = 0;
        bit ok = 1'b0;
        exp_t e;
        in_valid = 1'b1; in_idx = 8'(idx); in_mode = mode; in_last = last;
        while (!ok && n < 100) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            n++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!ok) begin
            check("beat_timeout", 32'd0, 32'd1);
        end else begin
            m_acc = m_acc | ref_dec(idx, mode);
            if (idx >= W) m_err = 1'b1;
            if (mode) m_therm = 1'b1;
            if (idx > m_max && idx < W) m_max = idx;
            if (last) begin
                e.mask = m_acc; e.err = m_err;
                e.chk_enc = !m_err && !m_therm; e.max_idx = m_max;
                q.push_back(e);
                model_clear();
                check("latency_out_valid", 32'(out_valid), 32'd1);
            end
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 300) begin
            @(posedge clk); n++;
        end
        #1;
        check("drain_empty", 32'(q.size()), 32'd0);
    endtask

    // Monitor: a frame is consumed at the next edge whenever valid and ready
    // are both high mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_frame", 32'(out_mask), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("out_mask", 32'(out_mask), 32'(e.mask));
                    check("out_err", 32'(out_err), 32'(e.err));
                    if (e.chk_enc) check("enc_round_trip", 32'(ref_enc(out_mask)), 32'(e.max_idx));
                end
            end
        end
    end

    // Random consumer back-pressure.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (rand_bp) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        int nb, idx;
        bit mode;
        rst = 1'b1; in_valid = 1'b0; in_idx = '0; in_mode = 1'b0; in_last = 1'b0;
        out_ready = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_mask", 32'(out_mask), 32'd0);
        check("rst_out_err", 32'(out_err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // One-hot 3, 9, 0.
        send_beat(3, 1'b0, 1'b0); send_beat(9, 1'b0, 1'b0); send_beat(0, 1'b0, 1'b1);
        check("dir_0209", 32'(out_mask), 32'h0209);
        check("dir_0209_err", 32'(out_err), 32'd0);
        check("dir_0209_enc", 32'(ref_enc(out_mask)), 32'd9);
        send_beat(5, 1'b1, 1'b1);
        check("dir_therm5", 32'(out_mask), 32'h003F);
        send_beat(15, 1'b1, 1'b1);
        check("dir_therm15", 32'(out_mask), 32'hFFFF);
        send_beat(15, 1'b0, 1'b1);
        check("dir_onehot15", 32'(out_mask), 32'h8000);
        send_beat(2, 1'b0, 1'b0); send_beat(20, 1'b0, 1'b1);
        check("dir_err_mask", 32'(out_mask), 32'h0004);
        check("dir_err_flag", 32'(out_err), 32'd1);
        send_beat(1, 1'b0, 1'b1);
        check("dir_err_clear_mask", 32'(out_mask), 32'h0002);
        check("dir_err_clear_flag", 32'(out_err), 32'd0);
        drain();

        // Stall with extra beats offered while holding.
        out_ready = 1'b0;
        send_beat(7, 1'b0, 1'b1);
        in_valid = 1'b1; in_idx = 8'd3; in_mode = 1'b0; in_last = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_mask", 32'(out_mask), 32'h0080);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_in_ready", 32'(in_ready), 32'd1);
        check("release_out_valid", 32'(out_valid), 32'd0);
        send_beat(1, 1'b0, 1'b1);
        check("no_stray_beat", 32'(out_mask), 32'h0002);
        drain();

        // Reset in the middle of a frame.
        send_beat(1, 1'b0, 1'b0); send_beat(4, 1'b0, 1'b0);
        model_clear();
        rst = 1'b1;
        @(negedge clk);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("midrst_in_ready2", 32'(in_ready), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_mask", 32'(out_mask), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_ready_after", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        send_beat(6, 1'b0, 1'b1);
        check("midrst_mask", 32'(out_mask), 32'h0040);
        drain();

        // Random frames with random back-pressure.
        rand_bp = 1'b1;
        for (int f = 0; f < 60; f++) begin
            nb = $urandom_range(1, 8);
            for (int b = 0; b < nb; b++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                if ($urandom_range(0, 9) == 0) idx = $urandom_range(W, 255);
                else idx = $urandom_range(0, W - 1);
                mode = 1'($urandom_range(0, 1));
                send_beat(idx, mode, b == nb - 1);
            end
        end
        rand_bp = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
